// File: rtl/ds18b20_onewire_master.sv
// DS18B20 1-Wire bus master: reset/presence, Skip ROM + Convert T, conversion
// wait, reset/presence, Skip ROM + Read Scratchpad, then read the temperature.
// Optional build macro DS18B20_CRC_EN: read all 9 scratchpad bytes and check
// the Dallas CRC-8 before accepting the temperature word.
`timescale 1ns/1ps
module ds18b20_onewire_master #(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int CONV_US     = 750000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        dq_in,
  output logic        dq_oe,
  output logic        busy,
  output logic [15:0] temp,
  output logic        temp_valid,
  output logic        no_presence,
  output logic        crc_err
);

  localparam int DIV = CLK_FREQ_HZ / 1000000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [19:0]   CONV_LIM  = 20'(CONV_US);

`ifdef DS18B20_CRC_EN
  localparam logic [3:0] LAST_BYTE = 4'd8;
`else
  localparam logic [3:0] LAST_BYTE = 4'd1;
`endif

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST_LOW,
    S_RST_PRES,
    S_RST_REC,
    S_WR_LOW,
    S_WR_REL,
    S_CONV_WAIT,
    S_RD_LOW,
    S_RD_REL,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [19:0]   us_cnt_q, us_cnt_d;
  logic          phase2_q, phase2_d;
  logic          cmd_idx_q, cmd_idx_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]    byte_cnt_q, byte_cnt_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    byte0_q, byte0_d;
  logic [15:0]   temp_q, temp_d;
  logic          temp_valid_q, temp_valid_d;
  logic          no_presence_q, no_presence_d;
  logic          busy_q, busy_d;
  logic          dq_oe_q, dq_oe_d;
`ifdef DS18B20_CRC_EN
  logic [7:0]    byte1_q, byte1_d;
  logic [7:0]    crc_q, crc_d;
  logic          crc_err_q, crc_err_d;
`endif

  logic        us_tick;
  logic [19:0] limit;
  logic        phase_done;
  logic        rd_sample;

  // Length in microseconds of the current timed phase. Write slots use the
  // bit being sent (tx_q[0]) to pick the short-low or long-low shape.
  function automatic logic [19:0] slot_limit(input state_t st, input logic bit1);
    logic [19:0] lim;
    case (st)
      S_RST_LOW:   lim = 20'd480;
      S_RST_PRES:  lim = 20'd70;
      S_RST_REC:   lim = 20'd410;
      S_WR_LOW:    lim = bit1 ? 20'd6 : 20'd60;
      S_WR_REL:    lim = bit1 ? 20'd64 : 20'd10;
      S_CONV_WAIT: lim = CONV_LIM;
      S_RD_LOW:    lim = 20'd6;
      S_RD_REL:    lim = 20'd64;
      default:     lim = 20'd1;
    endcase
    return lim;
  endfunction

`ifdef DS18B20_CRC_EN
  // One LSB-first step of the Dallas CRC-8 (reflected polynomial 0x8C).
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[0] ^ din;
    return {1'b0, crc[7:1]} ^ (fb ? 8'h8C : 8'h00);
  endfunction
`endif

  // The prescaler restarts on every phase entry so each phase lasts an exact
  // whole number of microseconds.
  assign us_tick    = (presc_q == PRESC_MAX);
  assign limit      = slot_limit(state_q, tx_q[0]);
  assign phase_done = us_tick && (us_cnt_q == limit - 20'd1);
  // Read sample point: end of the 9th us after release = 15 us into the slot.
  assign rd_sample  = us_tick && (us_cnt_q == 20'd8);

  // Next-state, sequencing and output logic.
  always_comb begin
    state_d       = state_q;
    presc_d       = presc_q;
    us_cnt_d      = us_cnt_q;
    phase2_d      = phase2_q;
    cmd_idx_d     = cmd_idx_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    tx_d          = tx_q;
    rx_d          = rx_q;
    byte0_d       = byte0_q;
    temp_d        = temp_q;
    temp_valid_d  = 1'b0;
    no_presence_d = no_presence_q;
`ifdef DS18B20_CRC_EN
    byte1_d       = byte1_q;
    crc_d         = crc_q;
    crc_err_d     = crc_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_RST_LOW;
          phase2_d      = 1'b0;
          no_presence_d = 1'b0;
`ifdef DS18B20_CRC_EN
          crc_err_d     = 1'b0;
`endif
        end
      end
      S_RST_LOW: begin
        if (phase_done) state_d = S_RST_PRES;
      end
      S_RST_PRES: begin
        if (phase_done) begin
          if (dq_in) begin
            no_presence_d = 1'b1;
            state_d       = S_IDLE;
          end else begin
            state_d = S_RST_REC;
          end
        end
      end
      S_RST_REC: begin
        if (phase_done) begin
          state_d   = S_WR_LOW;
          tx_d      = 8'hCC;
          cmd_idx_d = 1'b0;
          bit_cnt_d = 3'd0;
        end
      end
      S_WR_LOW: begin
        if (phase_done) state_d = S_WR_REL;
      end
      S_WR_REL: begin
        if (phase_done) begin
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            if (!cmd_idx_q) begin
              cmd_idx_d = 1'b1;
              tx_d      = phase2_q ? 8'hBE : 8'h44;
              state_d   = S_WR_LOW;
            end else if (!phase2_q) begin
              state_d = S_CONV_WAIT;
            end else begin
              state_d    = S_RD_LOW;
              byte_cnt_d = 4'd0;
`ifdef DS18B20_CRC_EN
              crc_d      = 8'h00;
`endif
            end
          end else begin
            tx_d      = {1'b0, tx_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            state_d   = S_WR_LOW;
          end
        end
      end
      S_CONV_WAIT: begin
        if (phase_done) begin
          phase2_d = 1'b1;
          state_d  = S_RST_LOW;
        end
      end
      S_RD_LOW: begin
        if (phase_done) state_d = S_RD_REL;
      end
      S_RD_REL: begin
        if (rd_sample) begin
          rx_d = {dq_in, rx_q[7:1]};
`ifdef DS18B20_CRC_EN
          if (byte_cnt_q < 4'd8) crc_d = crc8_step(crc_q, dq_in);
`endif
        end
        if (phase_done) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (byte_cnt_q == 4'd0) byte0_d = rx_q;
`ifdef DS18B20_CRC_EN
            if (byte_cnt_q == 4'd1) byte1_d = rx_q;
`endif
            if (byte_cnt_q == LAST_BYTE) begin
`ifdef DS18B20_CRC_EN
              if (rx_q == crc_q) begin
                temp_d       = {byte1_q, byte0_q};
                temp_valid_d = 1'b1;
                state_d      = S_DONE;
              end else begin
                crc_err_d = 1'b1;
                state_d   = S_IDLE;
              end
`else
              temp_d       = {rx_q, byte0_q};
              temp_valid_d = 1'b1;
              state_d      = S_DONE;
`endif
            end else begin
              byte_cnt_d = byte_cnt_q + 4'd1;
              state_d    = S_RD_LOW;
            end
          end else begin
            state_d = S_RD_LOW;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d  = (state_d != S_IDLE);
    dq_oe_d = (state_d == S_RST_LOW) || (state_d == S_WR_LOW) || (state_d == S_RD_LOW);

    if ((state_d != state_q) || (state_q == S_IDLE)) begin
      presc_d  = '0;
      us_cnt_d = '0;
    end else if (us_tick) begin
      presc_d  = '0;
      us_cnt_d = us_cnt_q + 20'd1;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      presc_q       <= '0;
      us_cnt_q      <= '0;
      phase2_q      <= 1'b0;
      cmd_idx_q     <= 1'b0;
      bit_cnt_q     <= 3'd0;
      byte_cnt_q    <= 4'd0;
      temp_q        <= 16'h0000;
      temp_valid_q  <= 1'b0;
      no_presence_q <= 1'b0;
      busy_q        <= 1'b0;
      dq_oe_q       <= 1'b0;
`ifdef DS18B20_CRC_EN
      crc_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      us_cnt_q      <= us_cnt_d;
      phase2_q      <= phase2_d;
      cmd_idx_q     <= cmd_idx_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      temp_q        <= temp_d;
      temp_valid_q  <= temp_valid_d;
      no_presence_q <= no_presence_d;
      busy_q        <= busy_d;
      dq_oe_q       <= dq_oe_d;
`ifdef DS18B20_CRC_EN
      crc_err_q     <= crc_err_d;
`endif
    end
  end

  // Shift/data registers; always loaded before use, so no reset needed.
  always_ff @(posedge clk) begin
    tx_q    <= tx_d;
    rx_q    <= rx_d;
    byte0_q <= byte0_d;
`ifdef DS18B20_CRC_EN
    byte1_q <= byte1_d;
    crc_q   <= crc_d;
`endif
  end

  assign dq_oe       = dq_oe_q;
  assign busy        = busy_q;
  assign temp        = temp_q;
  assign temp_valid  = temp_valid_q;
  assign no_presence = no_presence_q;
`ifdef DS18B20_CRC_EN
  assign crc_err     = crc_err_q;
`else
  assign crc_err     = 1'b0;
`endif

endmodule
